axi4_sram_slv: RTL and testbench



---
 rtl/axi4_sram_slv.sv | 207 ++++++++++++++++++++
 tb/tb_axi4_sram_slv.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_sram_slv.sv
// AXI4 slave bridging one transaction at a time onto a 1-cycle SRAM.
// INCR/FIXED bursts, round-robin AW/AR arbitration, DECERR/SLVERR checks.
module axi4_sram_slv #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int MEM_AW = 12
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   s_axi_awaddr,
    input  logic [7:0]          s_axi_awlen,
    input  logic [2:0]          s_axi_awsize,
    input  logic [1:0]          s_axi_awburst,
    input  logic                s_axi_awvalid,
    output logic                s_axi_awready,
    input  logic [DATA_W-1:0]   s_axi_wdata,
    input  logic [DATA_W/8-1:0] s_axi_wstrb,
    input  logic                s_axi_wlast,
    input  logic                s_axi_wvalid,
    output logic                s_axi_wready,
    output logic [1:0]          s_axi_bresp,
    output logic                s_axi_bvalid,
    input  logic                s_axi_bready,
    input  logic [ADDR_W-1:0]   s_axi_araddr,
    input  logic [7:0]          s_axi_arlen,
    input  logic [2:0]          s_axi_arsize,
    input  logic [1:0]          s_axi_arburst,
    input  logic                s_axi_arvalid,
    output logic                s_axi_arready,
    output logic [DATA_W-1:0]   s_axi_rdata,
    output logic [1:0]          s_axi_rresp,
    output logic                s_axi_rlast,
    output logic                s_axi_rvalid,
    input  logic                s_axi_rready,
    output logic                mem_en,
    output logic [DATA_W/8-1:0] mem_wen,
    output logic [MEM_AW-1:0]   mem_adr,
    output logic [DATA_W-1:0]   mem_wdat,
    input  logic [DATA_W-1:0]   mem_rdat
);

    typedef enum logic [2:0] {
        IDLE, WR_DATA, WR_RESP, RD_REQ, RD_DATA
    } state_t;

    state_t              state, state_nx;
    logic                prio;
    logic [MEM_AW-1:0]   cur;
    logic [7:0]          len;
    logic [7:0]          cnt;
    logic                fixed;
    logic [1:0]          err;
    logic                wl_err;
    logic [DATA_W-1:0]   rdata_q;
    logic                rd_new;
    logic                gnt_w, gnt_r;
    logic                last;
    logic                beat;
    logic [DATA_W-1:0]   rd_fresh;

    // Byte offsets are ignored: every access is a full aligned word.
    logic unused;
    assign unused = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    function automatic logic [1:0] chk_err(
        input logic [ADDR_W-1:0] a,
        input logic [2:0]        sz,
        input logic [1:0]        b
    );
        if (a[ADDR_W-1:MEM_AW+2] != '0)
            return 2'b11;
        else if (sz != 3'b010 || b[1])
            return 2'b10;
        else
            return 2'b00;
    endfunction

    assign gnt_w = s_axi_awvalid && (!s_axi_arvalid || prio);
    assign gnt_r = s_axi_arvalid && (!s_axi_awvalid || !prio);
    assign last  = (cnt == len);
    assign beat  = (state == WR_DATA && s_axi_wvalid) ||
                   (state == RD_DATA && s_axi_rready);
    assign rd_fresh = (err == 2'b00) ? mem_rdat : '0;

    // Next-state and all handshake / SRAM strobes; reset forces them idle.
    always_comb begin
        state_nx      = state;
        s_axi_awready = 1'b0;
        s_axi_arready = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_bvalid  = 1'b0;
        s_axi_bresp   = 2'b00;
        s_axi_rvalid  = 1'b0;
        s_axi_rresp   = 2'b00;
        s_axi_rlast   = 1'b0;
        s_axi_rdata   = '0;
        mem_en        = 1'b0;
        mem_wen       = '0;
        mem_adr       = '0;
        mem_wdat      = '0;
        unique case (state)
            IDLE: begin
                s_axi_awready = gnt_w;
                s_axi_arready = gnt_r;
                if (gnt_w)
                    state_nx = WR_DATA;
                else if (gnt_r)
                    state_nx = RD_REQ;
            end
            WR_DATA: begin
                s_axi_wready = 1'b1;
                if (s_axi_wvalid) begin
                    mem_en   = (err == 2'b00);
                    mem_wen  = (err == 2'b00) ? s_axi_wstrb : '0;
                    mem_adr  = cur;
                    mem_wdat = s_axi_wdata;
                    if (last)
                        state_nx = WR_RESP;
                end
            end
            WR_RESP: begin
                s_axi_bvalid = 1'b1;
                s_axi_bresp  = (err != 2'b00) ? err :
                               (wl_err ? 2'b10 : 2'b00);
                if (s_axi_bready)
                    state_nx = IDLE;
            end
            RD_REQ: begin
                mem_en   = (err == 2'b00);
                mem_adr  = cur;
                state_nx = RD_DATA;
            end
            RD_DATA: begin
                s_axi_rvalid = 1'b1;
                s_axi_rresp  = err;
                s_axi_rlast  = last;
                s_axi_rdata  = rd_new ? rd_fresh : rdata_q;
                if (s_axi_rready)
                    state_nx = last ? IDLE : RD_REQ;
            end
            default: state_nx = IDLE;
        endcase
        if (rst) begin
            s_axi_awready = 1'b0;
            s_axi_arready = 1'b0;
            s_axi_wready  = 1'b0;
            s_axi_bvalid  = 1'b0;
            s_axi_bresp   = 2'b00;
            s_axi_rvalid  = 1'b0;
            s_axi_rresp   = 2'b00;
            s_axi_rlast   = 1'b0;
            s_axi_rdata   = '0;
            mem_en        = 1'b0;
            mem_wen       = '0;
            mem_adr       = '0;
            mem_wdat      = '0;
        end
    end

    // State, burst context, arbitration priority and captured read word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            prio    <= 1'b0;
            cur     <= '0;
            len     <= '0;
            cnt     <= '0;
            fixed   <= 1'b0;
            err     <= 2'b00;
            wl_err  <= 1'b0;
            rdata_q <= '0;
            rd_new  <= 1'b0;
        end else begin
            state  <= state_nx;
            rd_new <= (state == RD_REQ);
            if (rd_new)
                rdata_q <= rd_fresh;
            if (state == IDLE && (gnt_w || gnt_r)) begin
                cnt    <= '0;
                wl_err <= 1'b0;
                if (s_axi_awvalid && s_axi_arvalid)
                    prio <= !prio;
                if (gnt_w) begin
                    cur   <= s_axi_awaddr[MEM_AW+1:2];
                    len   <= s_axi_awlen;
                    fixed <= (s_axi_awburst == 2'b00);
                    err   <= chk_err(s_axi_awaddr, s_axi_awsize,
                                     s_axi_awburst);
                end else begin
                    cur   <= s_axi_araddr[MEM_AW+1:2];
                    len   <= s_axi_arlen;
                    fixed <= (s_axi_arburst == 2'b00);
                    err   <= chk_err(s_axi_araddr, s_axi_arsize,
                                     s_axi_arburst);
                end
            end
            if (beat) begin
                cnt <= cnt + 8'd1;
                if (!fixed)
                    cur <= cur + MEM_AW'(1);
            end
            if (state == WR_DATA && s_axi_wvalid && (s_axi_wlast != last))
                wl_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_axi4_sram_slv.sv
// Randomized scoreboard bench for axi4_sram_slv with a word-array
// reference memory and a 1-cycle SRAM model attached to the mem_* port.
module tb_axi4_sram_slv;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid, awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast, wvalid, wready;
    logic [1:0]  bresp;
    logic        bvalid, bready;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid, arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast, rvalid, rready;
    logic        mem_en;
    logic [3:0]  mem_wen;
    logic [11:0] mem_adr;
    logic [31:0] mem_wdat;
    logic [31:0] mem_rdat;

    axi4_sram_slv dut (
        .clk(clk), .rst(rst),
        .s_axi_awaddr(awaddr), .s_axi_awlen(awlen),
        .s_axi_awsize(awsize), .s_axi_awburst(awburst),
        .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb),
        .s_axi_wlast(wlast), .s_axi_wvalid(wvalid),
        .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid),
        .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arlen(arlen),
        .s_axi_arsize(arsize), .s_axi_arburst(arburst),
        .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp),
        .s_axi_rlast(rlast), .s_axi_rvalid(rvalid),
        .s_axi_rready(rready),
        .mem_en(mem_en), .mem_wen(mem_wen), .mem_adr(mem_adr),
        .mem_wdat(mem_wdat), .mem_rdat(mem_rdat)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          mem_acc = 0;
    bit          stall_en = 1'b0;
    logic [31:0] sram    [4096];
    logic [31:0] ref_mem [4096];
    logic [31:0] wd [256];
    logic [3:0]  ws [256];
    logic [1:0]  bq [$];
    logic [34:0] rq [$];

    wire [46:0] all_o = {awready, arready, wready, bvalid, bresp,
                         rvalid, rresp, rlast, rdata,
                         mem_en, mem_wen};

    // SRAM model: byte-writable, read data one cycle after mem_en.
    always @(posedge clk) begin
        if (mem_en) begin
            mem_acc <= mem_acc + 1;
            if (mem_wen == 4'b0000)
                mem_rdat <= sram[mem_adr];
            else
                for (int b = 0; b < 4; b++)
                    if (mem_wen[b])
                        sram[mem_adr][8*b +: 8] <= mem_wdat[8*b +: 8];
        end
    end

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", nm, got, exp);
        end
    endtask

    // Monitor: compares every presented response with the queue head.
    always @(negedge clk) begin
        if (!rst) begin
            if (bvalid) begin
                if (bq.size() == 0) begin
                    chk("b_unexpected", {62'd0, bresp}, 64'hDEAD);
                end else begin
                    chk("bresp", {62'd0, bresp}, {62'd0, bq[0]});
                    if (bready) void'(bq.pop_front());
                end
            end
            if (rvalid) begin
                if (rq.size() == 0) begin
                    chk("r_unexpected", {29'd0, rdata, rresp, rlast},
                        64'hDEAD);
                end else begin
                    chk("r_beat", {29'd0, rdata, rresp, rlast},
                        {29'd0, rq[0]});
                    if (rready) void'(rq.pop_front());
                end
            end
        end
    end

    // Response-side ready drivers with optional random back-pressure.
    initial begin
        rready = 1'b1;
        bready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            rready = !stall_en || ($urandom_range(0, 2) != 0);
            bready = !stall_en || ($urandom_range(0, 2) != 0);
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    function automatic logic [1:0] exp_resp(input logic [31:0] a,
                                            input logic [2:0] sz,
                                            input logic [1:0] b);
        if (a >= 32'h0000_4000) return 2'b11;
        if (sz != 3'd2 || b >= 2'd2) return 2'b10;
        return 2'b00;
    endfunction

    function automatic int word_of(input logic [31:0] a, input int i,
                                   input logic [1:0] b);
        int base = int'(a[13:2]);
        return (base + ((b == 2'b01) ? i : 0)) % 4096;
    endfunction

    task automatic gen_wdata(input int n);
        for (int i = 0; i < n; i++) begin
            wd[i] = $urandom;
            ws[i] = 4'($urandom_range(0, 15));
        end
    endtask

    task automatic model_write(input logic [31:0] a, input int n,
                               input logic [1:0] b);
        for (int i = 0; i < n; i++) begin
            int w = word_of(a, i, b);
            for (int k = 0; k < 4; k++)
                if (ws[i][k]) ref_mem[w][8*k +: 8] = wd[i][8*k +: 8];
        end
    endtask

    task automatic push_rd(input logic [31:0] a, input logic [7:0] l,
                           input logic [2:0] sz, input logic [1:0] b);
        logic [1:0] e = exp_resp(a, sz, b);
        for (int i = 0; i <= int'(l); i++) begin
            logic [31:0] d = (e == 2'b00) ? ref_mem[word_of(a, i, b)] : 32'd0;
            rq.push_back({d, e, (i == int'(l))});
        end
    endtask

    task automatic set_aw(input logic [31:0] a, input logic [7:0] l,
                          input logic [2:0] sz, input logic [1:0] b);
        awaddr = a; awlen = l; awsize = sz; awburst = b; awvalid = 1'b1;
    endtask

    task automatic set_ar(input logic [31:0] a, input logic [7:0] l,
                          input logic [2:0] sz, input logic [1:0] b);
        araddr = a; arlen = l; arsize = sz; arburst = b; arvalid = 1'b1;
    endtask

    task automatic wait_aw();
        bit ok = 1'b0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (awready) begin ok = 1'b1; break; end
        end
        if (!ok) chk("aw_timeout", 0, 1);
        @(posedge clk); #1;
        awvalid = 1'b0;
    endtask

    task automatic wait_ar();
        bit ok = 1'b0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (arready) begin ok = 1'b1; break; end
        end
        if (!ok) chk("ar_timeout", 0, 1);
        @(posedge clk); #1;
        arvalid = 1'b0;
    endtask

    task automatic send_w(input int n, input int bad);
        for (int i = 0; i < n; i++) begin
            bit ok = 1'b0;
            if (stall_en) begin
                wvalid = 1'b0;
                repeat ($urandom_range(0, 5)) @(posedge clk);
                #1;
            end
            wvalid = 1'b1;
            wdata  = wd[i];
            wstrb  = ws[i];
            wlast  = (i == n - 1) ^ (i == bad);
            for (int t = 0; t < 200; t++) begin
                @(negedge clk);
                if (wready) begin ok = 1'b1; break; end
            end
            if (!ok) chk("w_timeout", 0, 1);
            @(posedge clk); #1;
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
        @(negedge clk);
        chk("bvalid_rise", {63'd0, bvalid}, 64'd1);
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int t = 0; t < 3000; t++) begin
            @(posedge clk);
            if (bq.size() == 0 && rq.size() == 0) begin ok = 1'b1; break; end
        end
        if (!ok) chk("idle_timeout", {32'd0, bq.size(), rq.size()}, 0);
        #1;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [7:0] l,
                            input logic [2:0] sz, input logic [1:0] b,
                            input int bad);
        logic [1:0] e = exp_resp(a, sz, b);
        if (e == 2'b00) model_write(a, int'(l) + 1, b);
        bq.push_back((bad >= 0 && e == 2'b00) ? 2'b10 : e);
        set_aw(a, l, sz, b);
        wait_aw();
        send_w(int'(l) + 1, bad);
        wait_idle();
    endtask

    task automatic do_read(input logic [31:0] a, input logic [7:0] l,
                           input logic [2:0] sz, input logic [1:0] b);
        push_rd(a, l, sz, b);
        set_ar(a, l, sz, b);
        wait_ar();
        wait_idle();
    endtask

    task automatic tie_round(input bit rd_first, input logic [31:0] a);
        gen_wdata(1);
        if (rd_first) push_rd(a, 0, 2, 1);
        else begin
            model_write(a, 1, 2'b01);
            bq.push_back(2'b00);
        end
        set_aw(a, 0, 2, 1);
        set_ar(a, 0, 2, 1);
        @(negedge clk);
        chk("tie_grant", {62'd0, arready, awready},
            rd_first ? 64'd2 : 64'd1);
        @(posedge clk); #1;
        if (rd_first) begin
            arvalid = 1'b0;
            wait_idle();
            model_write(a, 1, 2'b01);
            bq.push_back(2'b00);
            wait_aw();
            send_w(1, -1);
            wait_idle();
        end else begin
            awvalid = 1'b0;
            send_w(1, -1);
            wait_idle();
            push_rd(a, 0, 2, 1);
            wait_ar();
            wait_idle();
        end
    endtask

    initial begin
        int acc0;
        for (int i = 0; i < 4096; i++) begin
            logic [31:0] v = $urandom;
            sram[i] = v;
            ref_mem[i] = v;
        end
        mem_rdat = '0;
        rst = 1'b1;
        awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("outs_in_rst", {17'd0, all_o}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("outs_after_rst", {17'd0, all_o}, 64'd0);
        @(posedge clk); #1;

        wvalid = 1'b1;
        wdata  = 32'h1234_5678;
        @(negedge clk);
        chk("wready_idle", {63'd0, wready}, 64'd0);
        @(posedge clk); #1;
        wvalid = 1'b0;

        gen_wdata(1);
        wd[0] = 32'hDEAD_BEEF;
        ws[0] = 4'hF;
        do_write(32'h10, 0, 2, 1, -1);
        chk("sram_word4", {32'd0, sram[4]}, 64'hDEAD_BEEF);
        push_rd(32'h10, 0, 2, 1);
        set_ar(32'h10, 0, 2, 1);
        wait_ar();
        @(negedge clk);
        chk("rd_strobe", {47'd0, mem_en, mem_wen, mem_adr},
            {47'd0, 1'b1, 4'b0000, 12'd4});
        @(negedge clk);
        chk("rvalid_t2", {63'd0, rvalid}, 64'd1);
        wait_idle();

        gen_wdata(4);
        for (int i = 0; i < 4; i++) ws[i] = 4'hF;
        ws[2] = 4'b0101;
        do_write(32'h3FF8, 3, 2, 1, -1);
        do_read(32'h3FF8, 3, 2, 1);

        tie_round(1'b1, 32'h200);
        tie_round(1'b0, 32'h204);
        tie_round(1'b1, 32'h208);

        acc0 = mem_acc;
        do_read(32'h0001_0000, 1, 2, 1);
        chk("decerr_no_mem", 64'(mem_acc - acc0), 64'd0);
        acc0 = mem_acc;
        gen_wdata(1);
        do_write(32'h20, 0, 1, 1, -1);
        chk("slverr_no_mem", 64'(mem_acc - acc0), 64'd0);
        do_read(32'h30, 3, 2, 2'b10);
        gen_wdata(2);
        do_write(32'h40, 1, 2, 1, 0);
        do_read(32'h40, 1, 2, 1);

        stall_en = 1'b1;
        for (int k = 0; k < 6; k++) begin
            logic [31:0] a = {18'd0, 12'($urandom), 2'b00};
            logic [1:0]  b = 2'($urandom_range(0, 1));
            gen_wdata(8);
            do_write(a, 7, 2, b, -1);
            do_read(a, 7, 2, b);
            do_read({18'd0, 12'($urandom), 2'b00},
                    8'($urandom_range(0, 15)), 2, 1);
        end
        do_read(32'h3F00, 255, 2, 1);
        stall_en = 1'b0;
        @(posedge clk); #1;

        gen_wdata(4);
        set_aw(32'h400, 3, 2, 1);
        wait_aw();
        for (int i = 0; i < 2; i++) begin
            wvalid = 1'b1; wdata = wd[i]; wstrb = ws[i]; wlast = 1'b0;
            @(posedge clk); #1;
        end
        wvalid = 1'b1; wdata = wd[2]; wstrb = 4'hF;
        rst = 1'b1;
        @(negedge clk);
        chk("outs_rst_mid", {17'd0, all_o}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        wvalid = 1'b0;
        @(negedge clk);
        chk("outs_after_mid", {17'd0, all_o}, 64'd0);
        @(posedge clk); #1;
        model_write(32'h400, 2, 2'b01);
        do_read(32'h400, 3, 2, 1);

        chk("queues_empty", {32'd0, bq.size(), rq.size()}, 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
